// File: rtl/alu_multicycle_ctrl.sv
// Iterative sequencer for the slow ALU operations (ROR, MUL, SRA, SLL/SRL).
// One rotate/shift/add step per cycle; operands are latched when the request is accepted.
module alu_multicycle_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d, done_d, err_d, busy_d;

  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] neg_amt;
  logic [CW-1:0]    n_amt;
  logic             legal;

  // Shift amounts beyond the operand width behave like a full-width shift.
  function automatic logic [CW-1:0] sat_amt(input logic [WIDTH-1:0] v);
    if (32'(v) >= WIDTH) return CW'(WIDTH);
    return CW'(v);
  endfunction

  // Step count for a request presented on the inputs.
  always_comb begin
    neg_amt = ~data2 + WIDTH'(1);
    legal   = opcode[2];
    case (opcode)
      OP_ROR:  n_amt = CW'(32'(data2) % WIDTH);
      OP_MUL:  n_amt = CW'(WIDTH);
      OP_SRA:  n_amt = sat_amt(data2);
      3'b111:  n_amt = data2[WIDTH-1] ? sat_amt(neg_amt) : sat_amt(data2);
      default: n_amt = '0;
    endcase
  end

  // One iteration of the latched operation.
  always_comb begin
    case (op_q)
      OP_ROR:  acc_step = {acc_q[0], acc_q[WIDTH-1:1]};
      OP_MUL:  acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
      OP_SRA:  acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_step = dir_q ? {1'b0, acc_q[WIDTH-1:1]} : {acc_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      result   <= '0;
      zero     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      result   <= result_d;
      zero     <= zero_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
    end
  end

  // Next state, datapath and registered-output values.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dir_d    = dir_q;
    count_d  = count_q;
    result_d = result;
    zero_d   = zero;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = opcode;
          acc_d    = (opcode == OP_MUL) ? '0 : data1;
          mcand_d  = data1;
          mplier_d = data2;
          dir_d    = data2[WIDTH-1];
          count_d  = n_amt;
          if (n_amt == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (legal) begin
              result_d = data1;
              zero_d   = (data1 == '0);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = acc_step;
          zero_d   = (acc_step == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_alu_multicycle_ctrl.sv
// Bench for alu_multicycle_ctrl: arithmetic reference model checked every cycle,
// directed spec cases with literal expectations, then randomized traffic with sporadic resets.
module tb_alu_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       zero;
  logic       err;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;
  bit chk_en      = 1'b0;

  alu_multicycle_ctrl #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .data1  (data1),
    .data2  (data2),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of single-bit steps a request needs.
  function automatic int calc_n(input logic [2:0] op, input logic [7:0] d2);
    int b;
    b = 32'(d2);
    case (op)
      3'b100:  return b % 8;
      3'b101:  return 8;
      3'b110:  return (b > 8) ? 8 : b;
      3'b111:  begin
        if (b >= 128) b = 256 - b;
        return (b > 8) ? 8 : b;
      end
      default: return 0;
    endcase
  endfunction

  // Final result computed directly from the operation's arithmetic meaning.
  function automatic logic [7:0] calc_res(input logic [2:0] op, input logic [7:0] d1,
                                          input logic [7:0] d2);
    int a, s, n, r;
    a = 32'(d1);
    n = calc_n(op, d2);
    case (op)
      3'b100:  r = (a >> n) | (a << (8 - n));
      3'b101:  r = a * 32'(d2);
      3'b110:  begin
        s = (a >= 128) ? a - 256 : a;
        r = s >>> n;
      end
      3'b111:  r = (d2 >= 8'd128) ? (a >> n) : (a << n);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Reference model: an accepted request completes N edges later, then idles one edge after.
  logic       m_active, m_busy, m_done, m_err, m_zero, m_pill;
  logic [7:0] m_res, m_pres;
  int         m_dedge;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (reset) begin
      m_active <= 1'b0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
      m_res    <= 8'h00;
      m_zero   <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_busy   <= 1'b1;
        m_dedge  <= edge_n + calc_n(opcode, data2);
        m_pres   <= calc_res(opcode, data1, data2);
        m_pill   <= !opcode[2];
        if (calc_n(opcode, data2) == 0) begin
          m_done <= 1'b1;
          m_err  <= !opcode[2];
          if (opcode[2]) begin
            m_res  <= calc_res(opcode, data1, data2);
            m_zero <= (calc_res(opcode, data1, data2) == 8'h00);
          end
        end
      end
    end else if (edge_n == m_dedge) begin
      m_done <= 1'b1;
      m_err  <= m_pill;
      if (!m_pill) begin
        m_res  <= m_pres;
        m_zero <= (m_pres == 8'h00);
      end
    end else if (edge_n == m_dedge + 1) begin
      m_active <= 1'b0;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",   32'(busy),   32'(m_busy));
      chk("done",   32'(done),   32'(m_done));
      chk("err",    32'(err),    32'(m_err));
      chk("result", 32'(result), 32'(m_res));
      chk("zero",   32'(zero),   32'(m_zero));
    end
  end

  // Issue one request, wait for DONE, and check the literal outcome and latency.
  task automatic do_op(input string name, input logic [2:0] op, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] exp_res, input logic exp_zero,
                       input logic exp_err, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; opcode = op; data1 = d1; data2 = d2;
    @(posedge clk); #1;
    start = 1'b0; opcode = 3'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"},   32'(lat),    32'(exp_lat));
    chk({name, "_res"},   32'(result), 32'(exp_res));
    chk({name, "_zero"},  32'(zero),   32'(exp_zero));
    chk({name, "_err"},   32'(err),    32'(exp_err));
    chk({name, "_model"}, 32'(m_res),  32'(exp_res));
    @(posedge clk); #1;
    chk({name, "_idle"},  32'({busy, done}), 32'(0));
  endtask

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; opcode = 3'b000; data1 = 8'h00; data2 = 8'h00;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy",   32'(busy),   32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags",  32'({done, err, zero}), 32'(0));
    reset = 1'b0;

    do_op("mul13x11",  3'b101, 8'd13,  8'd11,  8'h8F, 1'b0, 1'b0, 8);
    do_op("illegal",   3'b001, 8'h55,  8'h03,  8'h8F, 1'b0, 1'b1, 0);
    do_op("mul_ovf",   3'b101, 8'h10,  8'h10,  8'h00, 1'b1, 1'b0, 8);
    do_op("ror3",      3'b100, 8'h81,  8'd3,   8'h30, 1'b0, 1'b0, 3);
    do_op("ror8",      3'b100, 8'h81,  8'd8,   8'h81, 1'b0, 1'b0, 0);
    do_op("sra2",      3'b110, 8'h90,  8'd2,   8'hE4, 1'b0, 1'b0, 2);
    do_op("sra200",    3'b110, 8'h90,  8'd200, 8'hFF, 1'b0, 1'b0, 8);
    do_op("sll1",      3'b111, 8'h81,  8'h01,  8'h02, 1'b0, 1'b0, 1);
    do_op("srl2",      3'b111, 8'h81,  8'hFE,  8'h20, 1'b0, 1'b0, 2);
    do_op("srl128",    3'b111, 8'h81,  8'h80,  8'h00, 1'b1, 1'b0, 8);

    // START held high with changing operands while busy must not disturb the running MUL.
    @(posedge clk); #1;
    start = 1'b1; opcode = 3'b101; data1 = 8'd3; data2 = 8'd5;
    @(posedge clk); #1;
    opcode = 3'b001; data1 = 8'hFF; data2 = 8'hFF;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("held_lat", 32'(lat),    32'(8));
    chk("held_res", 32'(result), 32'(15));
    chk("held_err", 32'(err),    32'(0));
    @(posedge clk); #1;
    chk("held_idle", 32'(busy), 32'(0));

    // Reset during step 4 of a MUL drops the operation.
    @(posedge clk); #1;
    start = 1'b1; opcode = 3'b101; data1 = 8'd13; data2 = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy",   32'(busy),   32'(0));
    chk("midrst_done",   32'(done),   32'(0));
    chk("midrst_result", 32'(result), 32'(0));
    repeat (10) begin
      @(posedge clk); #1;
      chk("midrst_nodone", 32'(done), 32'(0));
    end

    // Reset and start on the same edge: start is not accepted.
    start = 1'b1; reset = 1'b1; opcode = 3'b101; data1 = 8'd2; data2 = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'(0));

    repeat (3000) begin
      @(posedge clk); #1;
      reset  = ($urandom_range(0, 99) == 0);
      start  = ($urandom_range(0, 2) == 0);
      opcode = 3'($urandom);
      data1  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       data2 = 8'($urandom_range(0, 9));
        1:       data2 = 8'(256 - $urandom_range(1, 9));
        2:       data2 = 8'h80;
        default: data2 = 8'($urandom);
      endcase
    end
    reset = 1'b0; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
